// File: rtl/enum_seq_monitor.sv
// Checks the 2-bit ts0->ts1->ts2 state stream. It flags illegal encodings and
// out-of-order transitions, locks onto a clean sequence and counts completed rounds.
module enum_seq_monitor #(
    parameter int LOCK_LEN   = 3,
    parameter int CNT_W      = 8,
    parameter int ALLOW_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_state,
    input  logic             clr_err,
    output logic [1:0]       mon_state,
    output logic             lock,
    output logic [CNT_W-1:0] round_count,
    output logic [1:0]       last_state,
    output logic             err_illegal,
    output logic             err_order
);

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_SYNC   = 2'd1,
        M_LOCKED = 2'd2,
        M_ERROR  = 2'd3
    } mon_t;

    localparam logic [3:0] LOCK4 = 4'(LOCK_LEN);

    mon_t       st;
    logic [3:0] good_cnt;
    logic [1:0] succ;
    logic       s_ill, s_adv, s_hold, hold_ok, wrap;

    // Classify the incoming sample against the previous valid sample.
    always_comb begin
        succ    = (last_state == 2'd2) ? 2'd0 : last_state + 2'd1;
        s_ill   = (in_state == 2'd3);
        s_adv   = !s_ill && (in_state == succ);
        s_hold  = !s_ill && (in_state == last_state);
        hold_ok = s_hold && (ALLOW_HOLD != 0);
        wrap    = s_adv && (last_state == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= M_IDLE;
            good_cnt    <= '0;
            round_count <= '0;
            last_state  <= '0;
            err_illegal <= 1'b0;
            err_order   <= 1'b0;
        end else if (clr_err) begin
            // A sample coinciding with the clear is recorded but never classified.
            st          <= M_IDLE;
            good_cnt    <= '0;
            err_illegal <= 1'b0;
            err_order   <= 1'b0;
            if (in_valid)
                last_state <= in_state;
        end else if (in_valid) begin
            last_state <= in_state;
            case (st)
                M_IDLE: begin
                    if (in_state == 2'd0) begin
                        st       <= M_SYNC;
                        good_cnt <= '0;
                    end else if (s_ill) begin
                        st          <= M_ERROR;
                        err_illegal <= 1'b1;
                    end
                end
                M_SYNC: begin
                    if (s_ill) begin
                        st          <= M_ERROR;
                        err_illegal <= 1'b1;
                    end else if (s_adv) begin
                        good_cnt <= good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK4)
                            st <= M_LOCKED;
                    end else if (!hold_ok) begin
                        // Lost alignment before locking: resync quietly.
                        good_cnt <= '0;
                        st       <= (in_state == 2'd0) ? M_SYNC : M_IDLE;
                    end
                end
                M_LOCKED: begin
                    if (s_ill) begin
                        st          <= M_ERROR;
                        err_illegal <= 1'b1;
                    end else if (s_adv) begin
                        if (wrap)
                            round_count <= round_count + 1'b1;
                    end else if (!hold_ok) begin
                        st        <= M_ERROR;
                        err_order <= 1'b1;
                    end
                end
                M_ERROR: ;
            endcase
        end
    end

    assign mon_state = st;
    assign lock      = (st == M_LOCKED);

endmodule

// File: doc/enum_seq_monitor.md
Name: enum_seq_monitor

Overview:
- Downstream consumer of the 2-bit enumerated state stream from the ts0->ts1->ts2->ts0 sequencer (encodings ts0=0, ts1=1, ts2=2; ts3=3 is illegal).
- Checks every valid sample for legal encoding and legal transition order.
- Acquires lock after a run of correct transitions, counts completed rounds, and raises sticky error flags.
- Its own control is a typed enum FSM; all status outputs are registered.

Parameters:
- LOCK_LEN, 3: consecutive correct transitions in SYNC required to enter LOCKED (legal range 1..15).
- CNT_W, 8: width of round_count.
- ALLOW_HOLD, 1: 1 = a sample equal to the previous sample is legal (hold); 0 = hold is an order error.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state is sampled this cycle.
- in_state  in  2  enumerated state from the upstream sequencer.
- clr_err  in  1  clears sticky errors and the ERROR state.
- mon_state  out  2  monitor FSM: M_IDLE=0, M_SYNC=1, M_LOCKED=2, M_ERROR=3.
- lock  out  1  high iff mon_state==M_LOCKED.
- round_count  out  CNT_W  completed ts2->ts0 wraps seen while LOCKED.
- last_state  out  2  most recent valid in_state.
- err_illegal  out  1  sticky: an in_state==3 sample was seen.
- err_order  out  1  sticky: a wrong transition occurred while LOCKED.

Behaviour:
- Reset (rst=1 at an edge), all outputs registered:
  - mon_state=M_IDLE, lock=0, round_count=0, last_state=0, err_illegal=0, err_order=0.
  - Internal good_cnt=0 (width 4).
  - rst has priority over all other inputs; asserting it mid-operation discards any in-flight sample.
- Latency: a sample taken at edge N is reflected in every output after edge N (1 cycle).
- in_valid=0: no state change, no counter change. clr_err is still honoured.
- Expected successor: succ(0)=1, succ(1)=2, succ(2)=0.
- Classification of a valid sample s against last_state p:
  - illegal if s==3;
  - advance if s==succ(p);
  - hold if s==p;
  - wrong otherwise.
- last_state updates on every valid sample, including illegal ones.
- M_IDLE:
  - s==0 -> M_SYNC, good_cnt=0.
  - s==3 -> M_ERROR, err_illegal=1.
  - Anything else -> stay.
- M_SYNC:
  - advance: good_cnt++. If good_cnt+1==LOCK_LEN -> M_LOCKED.
  - hold with ALLOW_HOLD=1: no change.
  - wrong, or hold with ALLOW_HOLD=0: resync with no error flag. Go to M_SYNC with good_cnt=0 if s==0, else M_IDLE.
  - illegal -> M_ERROR, err_illegal=1.
- M_LOCKED:
  - advance: stay. If p==2 and s==0, round_count++ (wraps modulo 2^CNT_W, no saturation).
  - hold: legal if ALLOW_HOLD=1; otherwise treated as wrong.
  - wrong -> M_ERROR, err_order=1.
  - illegal -> M_ERROR, err_illegal=1.
- M_ERROR:
  - Samples are ignored for classification and flag setting; last_state still updates.
  - round_count is frozen.
  - Exits only via clr_err or rst.
- clr_err=1 in any state: next mon_state=M_IDLE; err_illegal=0, err_order=0, good_cnt=0.
  - round_count and last_state are kept.
  - A sample arriving in the same cycle is discarded for classification: it cannot set a flag or count a round.
- The first valid sample after reset or clear is compared against last_state. In M_IDLE, only the s==0 and s==3 rules apply.
- lock is combinationally decoded from registered mon_state, so no extra latency.

Test Plan:
- rst, then valid stream 0,1,2,0,1,2,0 (LOCK_LEN=3):
  - SYNC after sample 1; LOCKED after sample 4 (third advance).
  - round_count=1 after sample 7.
  - err flags both 0.
- Locked stream, then inject in_state=3 -> next cycle mon_state=3, err_illegal=1, lock=0. Further samples 0,1 change no flag and no count.
- Locked at last_state=1, then inject 0 -> err_order=1, mon_state=M_ERROR. Then clr_err=1 with in_state=3 valid in the same cycle -> M_IDLE, both flags 0, err_illegal stays 0.
- ALLOW_HOLD=0, LOCKED, sample 2 then 2:
  - ALLOW_HOLD=0 -> err_order=1.
  - Repeat with ALLOW_HOLD=1 -> stays LOCKED, round_count unchanged.
- CNT_W=2, locked, drive 4 full rounds -> round_count 1,2,3,0 (wrap), lock stays 1.
- rst pulse while LOCKED with round_count=2 -> all outputs 0 next cycle. in_valid=0 gaps inside a stream change nothing.
